// File: rtl/bit_serializer_pkg.sv
// Shared types and helpers for the bit_serializer slice.
// Optional feature macro: SERIALIZER_PARITY_EN (adds an even-parity trailer bit).
package bit_serializer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } state_e;

    // Legacy-style state constants used by the FSM register.
    localparam logic [1:0] IDLE   = ST_IDLE;
    localparam logic [1:0] SHIFT  = ST_SHIFT;
    localparam logic [1:0] PARITY = ST_PARITY;

    // Bit-counter width for a given word width (never below one bit).
    function automatic int unsigned cnt_w(input int unsigned width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/ser_bit_counter.sv
// Loadable down-counter for the serializer; flags when the count has reached zero.
// Optional feature macro: SERIALIZER_PARITY_EN (selects the load value in the parent).
module ser_bit_counter
    import bit_serializer_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned LOAD_VAL = WIDTH - 1
) (
    input  logic clock,
    input  logic reset,
    input  logic load,
    input  logic en,
    output logic last
);

    localparam int unsigned CNT_W = cnt_w(WIDTH);

    logic [CNT_W-1:0] count;

    // Load on frame start, count down while enabled, hold at zero.
    always_ff @(posedge clock) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= CNT_W'(LOAD_VAL);
        end else if (en && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign last = (count == '0);

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: accepts a word on valid/ready and shifts it out
// MSB first with a ser_valid qualifier and a frame_done pulse on the final bit.
// Optional feature macro: SERIALIZER_PARITY_EN (appends an even-parity bit; frame_done
// then marks the parity cycle).
module bit_serializer
    import bit_serializer_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter logic        IDLE_LEVEL = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             frame_done
);

    // With parity the counter tracks the last data bit (then PARITY follows);
    // without it the counter tracks the penultimate bit so frame_done can be
    // registered one edge ahead and then used to close the frame.
`ifdef SERIALIZER_PARITY_EN
    localparam int unsigned LOAD_VAL = WIDTH - 1;
`else
    localparam int unsigned LOAD_VAL = WIDTH - 2;
`endif

    logic [1:0]       state;
    logic [1:0]       state_d;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] sreg_d;
    logic             ser_out_d;
    logic             ser_valid_d;
    logic             frame_done_d;
    logic             cnt_load;
    logic             cnt_en;
    logic             cnt_last;

    ser_bit_counter #(
        .WIDTH    (WIDTH),
        .LOAD_VAL (LOAD_VAL)
    ) u_counter (
        .clock (clock),
        .reset (reset),
        .load  (cnt_load),
        .en    (cnt_en),
        .last  (cnt_last)
    );

    assign data_ready = (state == IDLE) & reset;

`ifdef SERIALIZER_PARITY_EN
    logic par_q;

    // Capture the even parity of the word at transfer time.
    always_ff @(posedge clock) begin
        if (!reset) begin
            par_q <= 1'b0;
        end else if (cnt_load) begin
            par_q <= ^data_in;
        end
    end
`endif

    // Next-state and next-output decode.
    always_comb begin
        state_d      = state;
        sreg_d       = sreg;
        ser_out_d    = IDLE_LEVEL;
        ser_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        cnt_load     = 1'b0;
        cnt_en       = 1'b0;

        case (state)
            IDLE: begin
                if (data_valid) begin
                    state_d     = SHIFT;
                    sreg_d      = {data_in[WIDTH-2:0], 1'b0};
                    ser_out_d   = data_in[WIDTH-1];
                    ser_valid_d = 1'b1;
                    cnt_load    = 1'b1;
                end
            end
            SHIFT: begin
`ifdef SERIALIZER_PARITY_EN
                if (cnt_last) begin
                    state_d      = PARITY;
                    ser_out_d    = par_q;
                    ser_valid_d  = 1'b1;
                    frame_done_d = 1'b1;
                end else begin
                    sreg_d      = {sreg[WIDTH-2:0], 1'b0};
                    ser_out_d   = sreg[WIDTH-1];
                    ser_valid_d = 1'b1;
                    cnt_en      = 1'b1;
                end
`else
                if (frame_done) begin
                    state_d = IDLE;
                end else begin
                    sreg_d      = {sreg[WIDTH-2:0], 1'b0};
                    ser_out_d   = sreg[WIDTH-1];
                    ser_valid_d = 1'b1;
                    if (cnt_last) begin
                        frame_done_d = 1'b1;
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
`endif
            end
`ifdef SERIALIZER_PARITY_EN
            PARITY: begin
                state_d = IDLE;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, shift register and registered outputs.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= IDLE;
            sreg       <= '0;
            ser_out    <= IDLE_LEVEL;
            ser_valid  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_d;
            sreg       <= sreg_d;
            ser_out    <= ser_out_d;
            ser_valid  <= ser_valid_d;
            frame_done <= frame_done_d;
        end
    end

endmodule

// File: tb/tb_bit_serializer.sv
// Self-checking bench for bit_serializer (WIDTH=8, IDLE_LEVEL=0).
// Honours SERIALIZER_PARITY_EN when the design is built with it.
module tb_bit_serializer;

    localparam int unsigned WIDTH = 8;

    logic             clock;
    logic             reset;
    logic [WIDTH-1:0] data_in;
    logic             data_valid;
    logic             data_ready;
    logic             ser_out;
    logic             ser_valid;
    logic             frame_done;

    int errors = 0;
    int checks = 0;

    bit   log_q[$];
    int   done_cnt = 0;

    typedef struct packed {
        logic b;
        logic done;
    } ent_t;

    ent_t exp_q[$];
    logic cur_valid = 1'b0;
    logic cur_b     = 1'b0;
    logic cur_done  = 1'b0;

    bit_serializer #(
        .WIDTH      (WIDTH),
        .IDLE_LEVEL (1'b0)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .ser_out    (ser_out),
        .ser_valid  (ser_valid),
        .frame_done (frame_done)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a frame is a queue of bits released one per clock;
    // a new word is taken only when no frame bit is showing.
    initial begin
        logic             r;
        logic             dv;
        logic [WIDTH-1:0] d;
        ent_t             e;
        forever begin
            @(posedge clock);
            r  = reset;
            dv = data_valid;
            d  = data_in;
            if (!r) begin
                exp_q.delete();
            end else if (!cur_valid && dv) begin
                for (int i = WIDTH - 1; i >= 0; i--) begin
`ifdef SERIALIZER_PARITY_EN
                    exp_q.push_back('{b: d[i], done: 1'b0});
`else
                    exp_q.push_back('{b: d[i], done: (i == 0)});
`endif
                end
`ifdef SERIALIZER_PARITY_EN
                exp_q.push_back('{b: ^d, done: 1'b1});
`endif
            end
            if (r && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cur_valid = 1'b1;
                cur_b     = e.b;
                cur_done  = e.done;
            end else begin
                cur_valid = 1'b0;
                cur_b     = 1'b0;
                cur_done  = 1'b0;
            end
            @(negedge clock);
            check("ser_valid", 32'(ser_valid), 32'(cur_valid));
            check("ser_out", 32'(ser_out), 32'(cur_b));
            check("frame_done", 32'(frame_done), 32'(cur_done));
            check("data_ready", 32'(data_ready), 32'(!cur_valid && reset));
            if (ser_valid === 1'b1) log_q.push_back(ser_out);
            if (frame_done === 1'b1) done_cnt++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #2;
    endtask

    // Offer a word and return how many edges passed until it was taken.
    task automatic send(input logic [WIDTH-1:0] w, output int waited);
        logic rdy;
        rdy        = 1'b0;
        data_in    = w;
        data_valid = 1'b1;
        waited     = 0;
        while (waited < 40) begin
            @(negedge clock);
            rdy = data_ready;
            @(posedge clock);
            #2;
            waited++;
            if (rdy === 1'b1) break;
        end
        if (rdy !== 1'b1) check("send_timeout", 32'(rdy), 32'd1);
    endtask

    function automatic logic [31:0] log_word();
        logic [31:0] v;
        v = '0;
        foreach (log_q[i]) v = {v[30:0], 1'(log_q[i])};
        return v;
    endfunction

    function automatic int count_110();
        int n;
        n = 0;
        for (int i = 2; i < log_q.size(); i++)
            if (log_q[i-2] && log_q[i-1] && !log_q[i]) n++;
        return n;
    endfunction

    task automatic clear_log();
        log_q.delete();
        done_cnt = 0;
    endtask

    initial begin
        int w;
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int frame_bits;
`ifdef SERIALIZER_PARITY_EN
        frame_bits = 9;
`else
        frame_bits = 8;
`endif
        reset      = 1'b0;
        data_valid = 1'b0;
        data_in    = '0;

        // 1: reset behaviour
        tick(2);
        check("rst_ready", 32'(data_ready), 32'd0);
        check("rst_valid", 32'(ser_valid), 32'd0);
        check("rst_out", 32'(ser_out), 32'd0);
        check("rst_done", 32'(frame_done), 32'd0);
        reset = 1'b1;
        #1;
        check("ready_after_release", 32'(data_ready), 32'd1);
        tick(1);

        // 2: single frame 8'hC0
        clear_log();
        send(8'hC0, w);
        data_valid = 1'b0;
        tick(12);
        check("c0_len", 32'(log_q.size()), 32'(frame_bits));
`ifdef SERIALIZER_PARITY_EN
        check("c0_bits", log_word(), 32'h180);
`else
        check("c0_bits", log_word(), 32'hC0);
`endif
        check("c0_done", 32'(done_cnt), 32'd1);
        check("c0_pattern_110", 32'(count_110()), 32'd1);

        // 3: back-to-back 8'hA5 then 8'h3C
        clear_log();
        send(8'hA5, w);
        send(8'h3C, w);
        data_valid = 1'b0;
        check("b2b_spacing", 32'(w), 32'(frame_bits + 1));
        tick(12);
`ifdef SERIALIZER_PARITY_EN
        check("b2b_bits", log_word(), 32'h29478);
`else
        check("b2b_bits", log_word(), 32'hA53C);
`endif
        check("b2b_done", 32'(done_cnt), 32'd2);

        // 4: data_in changes mid-frame
        clear_log();
        send(8'h0F, w);
        tick(3);
        data_in = 8'hFF;
        send(8'hFF, w);
        data_valid = 1'b0;
        check("hold_wait", 32'(w), 32'(frame_bits + 1 - 3));
        tick(12);
`ifdef SERIALIZER_PARITY_EN
        check("hold_bits", log_word(), 32'h3DFE);
`else
        check("hold_bits", log_word(), 32'h0FFF);
`endif
        check("hold_done", 32'(done_cnt), 32'd2);

        // 5: reset after bit 3 of 8'hFF
        clear_log();
        send(8'hFF, w);
        data_valid = 1'b0;
        tick(3);
        reset = 1'b0;
        tick(1);
        check("abort_valid", 32'(ser_valid), 32'd0);
        check("abort_out", 32'(ser_out), 32'd0);
        check("abort_done", 32'(frame_done), 32'd0);
        reset = 1'b1;
        tick(4);
        check("abort_len", 32'(log_q.size()), 32'd4);
        check("abort_bits", log_word(), 32'hF);
        check("abort_no_done", 32'(done_cnt), 32'd0);
        clear_log();
        send(8'h81, w);
        data_valid = 1'b0;
        tick(12);
`ifdef SERIALIZER_PARITY_EN
        check("post_abort_bits", log_word(), 32'h102);
`else
        check("post_abort_bits", log_word(), 32'h81);
`endif
        check("post_abort_done", 32'(done_cnt), 32'd1);

        // 6: 8'h07 (odd weight -> parity bit 1 when enabled)
        clear_log();
        send(8'h07, w);
        data_valid = 1'b0;
        tick(12);
`ifdef SERIALIZER_PARITY_EN
        check("w07_len", 32'(log_q.size()), 32'd9);
        check("w07_bits", log_word(), 32'h0F);
`else
        check("w07_len", 32'(log_q.size()), 32'd8);
        check("w07_bits", log_word(), 32'h07);
`endif
        check("w07_done", 32'(done_cnt), 32'd1);

        @(posedge clock);
        #2;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
